// File: rtl/serial_image_sender_pkg.sv
// Shared definitions for the serial image sender: FSM state encodings,
// default serial/image dimensions and the UART 8N1 frame builder.
package serial_image_sender_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL    = 4'd0,
        ST_LE_MEM     = 4'd1,
        ST_ESPERA_MEM = 4'd2,
        ST_CARREGA    = 4'd3,
        ST_TRANSMITE  = 4'd4,
        ST_GAP        = 4'd5,
        ST_PROXIMO    = 4'd6,
        ST_FIM        = 4'd7
    } state_t;

    localparam int DEF_BAUD_DIV = 434;
    localparam int DEF_IMG_W    = 64;
    localparam int DEF_IMG_H    = 64;
    localparam int FRAME_BITS   = 10;

    // Start bit (0) in the LSB, data LSB first, stop bit (1) in the MSB.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/serial_image_sender_tick_gen.sv
// Bit-time generator: counts BAUD_DIV enabled cycles and emits a one-cycle
// tick on the last cycle of each bit period. clear restarts the period.
module serial_tick_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    // Cycle counter within the current bit period, wrapping at BAUD_DIV.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/serial_image_sender.sv
// Streams a W x H byte image from a synchronous memory out of a UART 8N1
// TX line, one frame per pixel, with optional idle gap and pausa flow control.
module serial_image_sender
    import serial_image_sender_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int ADDR_W   = 12,
    parameter int GAP_BITS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              partida,
    input  logic              pausa,
    input  logic [7:0]        mem_dado,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              saida_serial,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_contagem
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_W-1:0]       counter;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [3:0]              bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic                    tick;
    logic                    tick_clear;
    logic                    tick_enable;
    logic                    start_ok;

    assign start_ok    = partida && (state == ST_INICIAL || state == ST_FIM);
    assign tick_clear  = (state == ST_CARREGA);
    assign tick_enable = (state == ST_TRANSMITE) || (state == ST_GAP);

    serial_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (tick_clear),
        .enable (tick_enable),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; pausa only matters between frames.
    always_comb begin
        next_state = state;
        case (state)
            ST_INICIAL:    if (partida) next_state = ST_LE_MEM;
            ST_LE_MEM:     next_state = ST_ESPERA_MEM;
            ST_ESPERA_MEM: next_state = ST_CARREGA;
            ST_CARREGA:    next_state = ST_TRANSMITE;
            ST_TRANSMITE: begin
                if (tick && bit_cnt == 4'(FRAME_BITS - 1)) begin
                    next_state = (GAP_BITS > 0) ? ST_GAP : ST_PROXIMO;
                end
            end
            ST_GAP:        if (tick && gap_cnt == LAST_GAP) next_state = ST_PROXIMO;
            ST_PROXIMO: begin
                if (counter == LAST_PIX) begin
                    next_state = ST_FIM;
                end else if (!pausa) begin
                    next_state = ST_LE_MEM;
                end
            end
            ST_FIM:        next_state = partida ? ST_LE_MEM : ST_INICIAL;
            default:       next_state = ST_INICIAL;
        endcase
    end

    // Output decode; the line is driven from the shift register only while transmitting.
    always_comb begin
        mem_rd       = (state == ST_LE_MEM);
        saida_serial = (state == ST_TRANSMITE) ? shift_reg[0] : 1'b1;
        ocupado      = (state != ST_INICIAL);
        pronto       = (state == ST_FIM);
        db_estado    = state;
        mem_addr     = counter;
        db_contagem  = counter;
    end

    // Pixel counter: cleared on every accepted start, advanced between frames.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (start_ok) begin
            counter <= '0;
        end else if (state == ST_PROXIMO && counter != LAST_PIX && !pausa) begin
            counter <= counter + ADDR_W'(1);
        end
    end

    // Bit and gap counters, restarted when a new frame is loaded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (state == ST_CARREGA) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (tick) begin
            if (state == ST_TRANSMITE) bit_cnt <= bit_cnt + 4'd1;
            if (state == ST_GAP)       gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // Frame shift register: loaded from memory data, shifted right once per bit time.
    always_ff @(posedge clock) begin
        if (state == ST_CARREGA) begin
            shift_reg <= make_frame(mem_dado);
        end else if (state == ST_TRANSMITE && tick) begin
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_image_sender.sv
// Bench for serial_image_sender: 2x2 image, 4-cycle bit time, one gap bit.
// Expected line/strobe timelines are built from the frame timing rules.
module tb_serial_image_sender;
    import serial_image_sender_pkg::*;

    localparam int B    = 4;
    localparam int IW   = 2;
    localparam int IH   = 2;
    localparam int AW   = 12;
    localparam int G    = 1;
    localparam int NPIX = IW * IH;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          partida = 1'b0;
    logic          pausa = 1'b0;
    logic [7:0]    mem_dado = 8'h00;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          saida_serial;
    logic          ocupado;
    logic          pronto;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_contagem;

    int checks = 0;
    int errors = 0;

    serial_image_sender #(
        .BAUD_DIV (B),
        .IMG_W    (IW),
        .IMG_H    (IH),
        .ADDR_W   (AW),
        .GAP_BITS (G)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .pausa        (pausa),
        .mem_dado     (mem_dado),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado),
        .db_contagem  (db_contagem)
    );

    always #5 clock = ~clock;

    // Synchronous image memory, data one cycle after the read strobe.
    logic [7:0] mem [NPIX];
    always @(posedge clock) begin
        if (mem_rd) mem_dado <= mem[int'(mem_addr) % NPIX];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // UART receiver: samples mid-bit, pushes each decoded byte.
    bit         dact = 1'b0;
    int         dcnt = 0;
    logic [7:0] dsh = 8'h00;
    logic [7:0] dec_q[$];
    always @(negedge clock) begin
        if (reset) begin
            dact <= 1'b0;
        end else if (!dact) begin
            if (saida_serial === 1'b0) begin
                dact <= 1'b1;
                dcnt <= 1;
            end
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt >= B + B/2 && dcnt < 9*B && (dcnt % B) == B/2)
                dsh <= {saida_serial, dsh[7:1]};
            if (dcnt == 9*B + B/2) begin
                dec_q.push_back(dsh);
                dact <= 1'b0;
            end
        end
    end

    // Expected per-cycle timeline.
    bit m_line[$];
    bit m_rd[$];
    bit m_pr[$];
    bit m_busy[$];
    int m_addr[$];
    int start_idx[NPIX];

    task automatic push(input bit l, input bit r, input bit p, input bit b, input int a);
        m_line.push_back(l);
        m_rd.push_back(r);
        m_pr.push_back(p);
        m_busy.push_back(b);
        m_addr.push_back(a);
    endtask

    // Cycle 0 is idle with partida presented; each byte costs a fetch of
    // 3 high cycles, 10 bits of B cycles, G*B gap cycles, plus one
    // inter-frame cycle (stretched while pausa is held).
    task automatic build(input int pe, input int pause_byte);
        m_line.delete(); m_rd.delete(); m_pr.delete(); m_busy.delete(); m_addr.delete();
        push(1, 0, 0, 0, -1);
        for (int i = 0; i < NPIX; i++) begin
            logic [9:0] fr;
            if (i > 0) begin
                int q = m_line.size();
                int n = (i == pause_byte && pe > q) ? pe - q + 1 : 1;
                repeat (n) push(1, 0, 0, 1, -1);
            end
            push(1, 1, 0, 1, i);
            push(1, 0, 0, 1, -1);
            push(1, 0, 0, 1, -1);
            start_idx[i] = m_line.size();
            fr = {1'b1, mem[i], 1'b0};
            for (int b = 0; b < 10; b++) repeat (B) push(fr[b], 0, 0, 1, -1);
            repeat (G * B) push(1, 0, 0, 1, -1);
        end
        push(1, 0, 0, 1, -1);
        push(1, 0, 1, 1, -1);
        repeat (3) push(1, 0, 0, 0, -1);
    endtask

    task automatic run(input int ps, input int pe, input int extra_start, input int stop_at,
                       output int first_low);
        int npr = 0;
        first_low = -1;
        for (int j = 0; j < m_line.size(); j++) begin
            @(negedge clock);
            check($sformatf("line@%0d", j), saida_serial, m_line[j]);
            check($sformatf("mem_rd@%0d", j), mem_rd, m_rd[j]);
            check($sformatf("pronto@%0d", j), pronto, m_pr[j]);
            check($sformatf("ocupado@%0d", j), ocupado, m_busy[j]);
            if (m_addr[j] >= 0) begin
                check($sformatf("addr@%0d", j), mem_addr, m_addr[j]);
                check($sformatf("contagem@%0d", j), db_contagem, m_addr[j]);
            end
            if (m_pr[j]) check($sformatf("estado_fim@%0d", j), db_estado, ST_FIM);
            if (pronto) npr++;
            if (pe >= 0 && j >= pe && first_low < 0 && !saida_serial) first_low = j;
            if (j == stop_at) return;
            partida = (j == 0) || (j == extra_start);
            pausa   = (j >= ps && j < pe);
        end
        partida = 1'b0;
        pausa   = 1'b0;
        check("pronto_count", npr, 1);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, dec_q.size(), NPIX);
        for (int i = 0; i < NPIX && i < dec_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), dec_q[i], mem[i]);
        dec_q.delete();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int fl;
        int ps;
        int pe;
        mem[0] = 8'h55; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'hA3;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_line", saida_serial, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_contagem", db_contagem, 0);
        check("rst_estado", db_estado, ST_INICIAL);
        reset = 1'b0;

        // Fixed image 55,00,FF,A3.
        build(-1, -1);
        run(-1, -1, -1, -1, fl);
        check_bytes("fixed");

        // pausa raised during byte 1, held 50 cycles.
        build(-1, -1);
        ps = start_idx[1] + int'($urandom_range(0, 30));
        pe = ps + 50;
        build(pe, 2);
        run(ps, pe, -1, -1, fl);
        check("resume_delay", fl - pe, 4);
        check_bytes("pause");

        // Second partida mid-image is ignored.
        randomize_mem();
        build(-1, -1);
        run(-1, -1, start_idx[1] + int'($urandom_range(0, 20)), -1, fl);
        check_bytes("repartida");

        // Async reset in the middle of byte 2 data bits, then full restart.
        randomize_mem();
        build(-1, -1);
        run(-1, -1, -1, start_idx[2] + 3 * B + 1, fl);
        #1 reset = 1'b1;
        #1;
        check("midrst_line", saida_serial, 1);
        check("midrst_ocupado", ocupado, 0);
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_addr", mem_addr, 0);
        partida = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        dec_q.delete();
        run(-1, -1, -1, -1, fl);
        check_bytes("after_rst");

        // Random images, some with pausa.
        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            build(-1, -1);
            if (r == 1) begin
                ps = start_idx[1] + int'($urandom_range(0, 40));
                pe = ps + int'($urandom_range(10, 60));
                build(pe, 2);
                run(ps, pe, -1, -1, fl);
            end else begin
                run(-1, -1, -1, -1, fl);
            end
            check_bytes($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
